// File: rtl/axil_if.sv
// AXI4-Lite bus bundle between an interconnect master port and a register slave.
interface axil_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int STRB_WIDTH = DATA_WIDTH / 8 + 1
) ();
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [RESP_WIDTH-1:0] bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [RESP_WIDTH-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: 16-byte window with REG0, REG1, a REG0 mirror and a write counter.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int STRB_WIDTH = DATA_WIDTH / 8 + 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic   s_axi_aclk,
  input logic   s_axi_areset,
  axil_if.slave s_axi
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  function automatic logic is_hit(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [NBYTES-1:0]     strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int i = 0; i < NBYTES; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NBYTES-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] reg0_q, reg0_d, reg1_q, reg1_d, wcnt_q, wcnt_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [NBYTES-1:0]     c_strb;
  logic                  unused_bits;

  assign aw_hs = s_axi.awvalid & awready_q;
  assign w_hs  = s_axi.wvalid & wready_q;
  assign ar_hs = s_axi.arvalid & arready_q;
  assign unused_bits = ^{c_addr[1:0], s_axi.wstrb[STRB_WIDTH-1], s_axi.araddr[1:0]};

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    reg0_d   = reg0_q;
    reg1_d   = reg1_q;
    wcnt_d   = wcnt_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    c_addr   = s_axi.awaddr;
    c_data   = s_axi.wdata;
    c_strb   = s_axi.wstrb[NBYTES-1:0];
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d = s_axi.awaddr;
          wstate_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb[NBYTES-1:0];
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        c_addr = awaddr_q;
        commit = w_hs;
      end
      W_HAVE_W: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        commit = aw_hs;
      end
      W_RESP: begin
        if (bvalid_q && s_axi.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    // Only offsets 0x0/0x4 are writable; everything else answers SLVERR without side effects.
    if (commit) begin
      wstate_d = W_RESP;
      if (is_hit(c_addr) && !c_addr[3]) begin
        if (c_addr[2]) reg1_d = merge_bytes(reg1_q, c_data, c_strb);
        else           reg0_d = merge_bytes(reg0_q, c_data, c_strb);
        wcnt_d  = wcnt_q + DATA_WIDTH'(1);
        bresp_d = RESP_OKAY;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end
    awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_W);
    wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_AW);
    bvalid_d  = (wstate_d == W_RESP);
  end

  // Reads sample the current (pre-commit) register values.
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          if (is_hit(s_axi.araddr)) begin
            rresp_d = RESP_OKAY;
            case (s_axi.araddr[3:2])
              2'd0:    rdata_d = reg0_q;
              2'd1:    rdata_d = reg1_q;
              2'd2:    rdata_d = reg0_q;
              default: rdata_d = wcnt_q;
            endcase
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end
        end
      end
      R_DATA: begin
        if (s_axi.rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
    rvalid_d  = (rstate_d == R_DATA);
  end

  always_ff @(posedge s_axi_aclk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
    if (s_axi_areset) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      reg0_q    <= '0;
      reg1_q    <= '0;
      wcnt_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      wcnt_q    <= wcnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: two windows (base 0x00 and 0x10) against a register-map model.
module tb_axil_reg_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][7:0]  awaddr, araddr;
  logic [1:0][31:0] wdata, rdata;
  logic [1:0][4:0]  wstrb;
  logic [1:0][2:0]  bresp, rresp;
  logic [1:0]       awvalid, wvalid, bready, arvalid, rready;
  logic [1:0]       awready, wready, bvalid, arready, rvalid;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    axil_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .STRB_WIDTH(5)) bus ();
    assign bus.awaddr  = awaddr[g];
    assign bus.awvalid = awvalid[g];
    assign bus.wdata   = wdata[g];
    assign bus.wstrb   = wstrb[g];
    assign bus.wvalid  = wvalid[g];
    assign bus.bready  = bready[g];
    assign bus.araddr  = araddr[g];
    assign bus.arvalid = arvalid[g];
    assign bus.rready  = rready[g];
    assign awready[g]  = bus.awready;
    assign wready[g]   = bus.wready;
    assign bvalid[g]   = bus.bvalid;
    assign bresp[g]    = bus.bresp;
    assign arready[g]  = bus.arready;
    assign rvalid[g]   = bus.rvalid;
    assign rdata[g]    = bus.rdata;
    assign rresp[g]    = bus.rresp;

    axil_reg_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .STRB_WIDTH(5),
      .BASE_ADDR(8'(g * 16))
    ) u_dut (
      .s_axi_aclk  (clk),
      .s_axi_areset(rst),
      .s_axi       (bus)
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference register map, one set per window.
  logic [31:0] m_reg0 [2];
  logic [31:0] m_reg1 [2];
  logic [31:0] m_wcnt [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_reg0[i] = 0;
      m_reg1[i] = 0;
      m_wcnt[i] = 0;
    end
  endfunction

  function automatic void model_write(input int d, input logic [7:0] a, input logic [31:0] data,
                                      input logic [3:0] strb, output logic [2:0] resp);
    int off;
    off = (int'(a) % 16) / 4;
    if ((int'(a) / 16) == d && off < 2) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) begin
          if (off == 0) m_reg0[d][8*i +: 8] = data[8*i +: 8];
          else          m_reg1[d][8*i +: 8] = data[8*i +: 8];
        end
      end
      m_wcnt[d] = m_wcnt[d] + 1;
      resp = 3'd0;
    end else begin
      resp = 3'd2;
    end
  endfunction

  function automatic void model_read(input int d, input logic [7:0] a,
                                     output logic [31:0] data, output logic [2:0] resp);
    int off;
    off = (int'(a) % 16) / 4;
    if ((int'(a) / 16) != d) begin
      data = 0;
      resp = 3'd2;
    end else begin
      resp = 3'd0;
      if (off == 0 || off == 2) data = m_reg0[d];
      else if (off == 1)        data = m_reg1[d];
      else                      data = m_wcnt[d];
    end
  endfunction

  // w_lead > 0: W offered that many cycles before AW; < 0: AW first.
  task automatic do_write(input int d, input logic [7:0] a, input logic [31:0] data,
                          input logic [4:0] strb, input int w_lead, input int bhold);
    int aw_at, w_at, cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [2:0] er;
    aw_at = (w_lead > 0) ? w_lead : 0;
    w_at  = (w_lead < 0) ? -w_lead : 0;
    cyc = 0; aw_done = 0; w_done = 0;
    model_write(d, a, data, strb[3:0], er);
    awaddr[d] = a; wdata[d] = data; wstrb[d] = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid[d] = !aw_done && cyc >= aw_at;
      wvalid[d]  = !w_done && cyc >= w_at;
      aw_hs = awvalid[d] && awready[d];
      w_hs  = wvalid[d] && wready[d];
      tick();
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      if (w_hs && !aw_done) check("wready_drop", wready[d], 0);
      if (aw_hs && !w_done) check("awready_drop", awready[d], 0);
    end
    awvalid[d] = 0; wvalid[d] = 0;
    check("write_accept", aw_done && w_done, 1);
    check("bvalid", bvalid[d], 1);
    check("bresp", bresp[d], er);
    for (int i = 0; i < bhold; i++) begin
      tick();
      check("bvalid_hold", bvalid[d], 1);
      check("bresp_hold", bresp[d], er);
      check("awready_hold", awready[d], 0);
      check("wready_hold", wready[d], 0);
    end
    bready[d] = 1;
    tick();
    bready[d] = 0;
    check("bvalid_drop", bvalid[d], 0);
    check("awready_back", awready[d], 1);
  endtask

  task automatic do_read(input int d, input logic [7:0] a, input int rhold);
    logic [31:0] ed;
    logic [2:0] er;
    int cyc;
    bit done;
    cyc = 0; done = 0;
    model_read(d, a, ed, er);
    araddr[d] = a;
    while (!done && cyc < 50) begin
      arvalid[d] = 1;
      done = arready[d];
      tick();
      cyc++;
    end
    arvalid[d] = 0;
    check("read_accept", done, 1);
    check("rvalid", rvalid[d], 1);
    check("rdata", rdata[d], ed);
    check("rresp", rresp[d], er);
    for (int i = 0; i < rhold; i++) begin
      tick();
      check("rvalid_hold", rvalid[d], 1);
      check("rdata_hold", rdata[d], ed);
      check("arready_hold", arready[d], 0);
    end
    rready[d] = 1;
    tick();
    rready[d] = 0;
    check("rvalid_drop", rvalid[d], 0);
    check("arready_back", arready[d], 1);
  endtask

  // Write commit and read handshake on the same edge, both responses back-pressured.
  task automatic do_concurrent(input int d, input logic [7:0] wa, input logic [31:0] data,
                               input logic [4:0] strb, input logic [7:0] ra, input int hold);
    logic [31:0] ed;
    logic [2:0] er, eb;
    model_read(d, ra, ed, er);
    model_write(d, wa, data, strb[3:0], eb);
    check("cc_awready", awready[d], 1);
    check("cc_wready", wready[d], 1);
    check("cc_arready", arready[d], 1);
    awaddr[d] = wa; wdata[d] = data; wstrb[d] = strb; araddr[d] = ra;
    awvalid[d] = 1; wvalid[d] = 1; arvalid[d] = 1;
    tick();
    awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0;
    for (int i = 0; i <= hold; i++) begin
      check("cc_bvalid", bvalid[d], 1);
      check("cc_bresp", bresp[d], eb);
      check("cc_rvalid", rvalid[d], 1);
      check("cc_rdata", rdata[d], ed);
      check("cc_rresp", rresp[d], er);
      check("cc_awready_low", awready[d], 0);
      check("cc_arready_low", arready[d], 0);
      if (i < hold) tick();
    end
    bready[d] = 1; rready[d] = 1;
    tick();
    bready[d] = 0; rready[d] = 0;
    check("cc_bvalid_drop", bvalid[d], 0);
    check("cc_rvalid_drop", rvalid[d], 0);
  endtask

  initial begin
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    model_reset();
    rst = 1;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_awready", awready[d], 0);
      check("rst_wready", wready[d], 0);
      check("rst_bvalid", bvalid[d], 0);
      check("rst_bresp", bresp[d], 0);
      check("rst_arready", arready[d], 0);
      check("rst_rvalid", rvalid[d], 0);
      check("rst_rdata", rdata[d], 0);
      check("rst_rresp", rresp[d], 0);
    end
    rst = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      check("post_rst_awready", awready[d], 1);
      check("post_rst_wready", wready[d], 1);
      check("post_rst_arready", arready[d], 1);
    end

    do_write(0, 8'h00, 32'hDEADBEEF, 5'h0F, 0, 0);
    do_read(0, 8'h08, 0);
    do_read(0, 8'h0C, 0);
    do_write(0, 8'h04, 32'h12345678, 5'h0F, 3, 0);
    do_read(0, 8'h04, 0);
    do_write(0, 8'h04, 32'hAABBCCDD, 5'h05, 0, 0);
    do_read(0, 8'h04, 0);
    do_read(0, 8'h0C, 0);
    do_write(0, 8'h0C, 32'hFFFFFFFF, 5'h1F, 0, 0);
    do_write(1, 8'h00, 32'h55555555, 5'h0F, 0, 0);
    do_write(0, 8'h00, 32'h0, 5'h10, -2, 0);
    do_read(0, 8'h40, 0);
    do_read(0, 8'h0C, 0);
    do_read(1, 8'h1C, 0);
    do_read(1, 8'h10, 0);
    do_write(1, 8'h17, 32'hCAFEF00D, 5'h0F, 1, 5);
    do_read(1, 8'h14, 5);
    do_concurrent(0, 8'h00, 32'h0BADF00D, 5'h0F, 8'h08, 5);
    do_concurrent(0, 8'h04, 32'h01020304, 5'h03, 8'h0C, 2);
    do_read(0, 8'h08, 0);

    for (int n = 0; n < 60; n++) begin
      int d;
      logic [7:0] a;
      d = int'($urandom_range(1));
      a = 8'($urandom_range(8'h3F));
      if ($urandom_range(1) == 1)
        do_write(d, a, $urandom, 5'($urandom), int'($urandom_range(6)) - 3,
                 int'($urandom_range(2)));
      else
        do_read(d, a, int'($urandom_range(2)));
    end

    do_write(0, 8'h00, 32'h1, 5'h0F, 0, 0);
    awaddr[0] = 8'h04; wdata[0] = 32'h77; wstrb[0] = 5'h0F;
    awvalid[0] = 1; wvalid[0] = 1;
    tick();
    awvalid[0] = 0; wvalid[0] = 0;
    check("mid_bvalid", bvalid[0], 1);
    rst = 1;
    tick();
    model_reset();
    check("mid_rst_bvalid", bvalid[0], 0);
    check("mid_rst_awready", awready[0], 0);
    rst = 0;
    tick();
    check("mid_rst_awready_back", awready[0], 1);
    do_read(0, 8'h00, 0);
    do_read(0, 8'h04, 0);
    do_read(0, 8'h0C, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite memory-mapped register slave that sits directly downstream of the bus block's master ports (m1_* or m2_*). One instance per slave window.
- Decodes a 16-byte window at BASE_ADDR: two read/write registers, one read-only mirror, and one read-only write counter.
- Write and read channels are independent; each runs its own FSM with full valid/ready handshakes and SLVERR on illegal accesses.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 8, address width in bits.
- RESP_WIDTH, 3, response field width; matches the bus block.
- STRB_WIDTH, DATA_WIDTH/8+1, strobe width; matches the bus block's port. Only bits [DATA_WIDTH/8-1:0] are used; the MSB is ignored.
- BASE_ADDR, 0, window base. Must be 16-byte aligned (instance 1 = 0, instance 2 = 16).

Ports:
- s_axi_aclk  in  1  single clock.
- s_axi_areset  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  STRB_WIDTH  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  RESP_WIDTH  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  RESP_WIDTH  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.

Behaviour:
- Reset: sampled on s_axi_aclk only. While asserted, every output = 0, REG0 = REG1 = WCNT = 0, both FSMs go to IDLE. Ready signals rise on the first clock after reset deasserts. Reset mid-transaction drops the transaction silently.
- Decode: hit when addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]. Offset = addr[3:2]; addr[1:0] ignored.
- Register map:
  - 0x0 REG0: RW.
  - 0x4 REG1: RW.
  - 0x8 MIRROR: RO, returns REG0.
  - 0xC WCNT: RO, count of successful writes, wraps 2^DATA_WIDTH-1 -> 0.
- Response codes: OKAY = 0, SLVERR = 2, zero-extended to RESP_WIDTH.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready = wready = 1.
    - Both handshakes in the same cycle -> commit, go to W_RESP.
    - AW only -> latch address, go to W_HAVE_AW (awready = 0).
    - W only -> latch data and strobe, go to W_HAVE_W (wready = 0).
  - W_HAVE_AW / W_HAVE_W: wait for the missing handshake, then commit and go to W_RESP.
  - Commit: on hit with offset 0x0/0x4, update each byte i whose wstrb[i] = 1; WCNT += 1; bresp = OKAY. Offsets 0x8/0xC or a miss: no state change, WCNT unchanged, bresp = SLVERR. An all-zero strobe to a RW register is still OKAY and still increments WCNT.
  - W_RESP: bvalid = 1 and bresp stable; awready = wready = 0. On bvalid & bready -> W_IDLE, bvalid = 0 the next cycle.
  - Latency: final handshake at edge N -> bvalid high from edge N+1. Minimum 2 cycles per write.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On arvalid & arready, register rdata/rresp from current register values, go to R_DATA.
  - Miss: rdata = 0, rresp = SLVERR. All four offsets are readable on hit.
  - R_DATA: rvalid = 1, arready = 0, rdata/rresp stable. On rready -> R_IDLE.
  - Latency: AR handshake at edge N -> rvalid from N+1. Minimum 2 cycles per read.
- Simultaneous events:
  - A read handshake in the same cycle as a write commit returns pre-write values, for all offsets including MIRROR and WCNT.
  - Back-pressure: bvalid/rvalid held indefinitely while bready/rready = 0; no new address is accepted on that channel meanwhile.

Test Plan:
- Reset, then with BASE_ADDR=0 write 0x0 data 0xDEADBEEF wstrb 0x0F (AW and W same cycle) -> bvalid next cycle, bresp=0; read 0x8 -> rdata 0xDEADBEEF, rresp 0; read 0xC -> 1.
- W presented 3 cycles before AW at 0x4, data 0x12345678 strb 0xF -> wready drops after the W handshake; bvalid 1 cycle after the AW handshake; read 0x4 = 0x12345678.
- Write 0x4 data 0xAABBCCDD wstrb 0x05 over 0x12345678 -> read 0x4 = 0x12BB56DD; WCNT increments.
- Write to 0xC, and with BASE_ADDR=16 write to 0x00 -> bresp=2, WCNT and registers unchanged; read 0x40 -> rresp=2, rdata 0.
- Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid/bresp/rdata stable, awready/arready=0; release -> each valid drops the next cycle.
- Assert reset while in W_RESP with REG0=0x1 -> bvalid=0 and REG0=0 the next cycle; first read afterwards returns 0.
